// File: rtl/main_unit_pkg.sv
// main_unit_pkg: shared state, regime codes and step counts for the iterative arithmetic unit
package main_unit_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [1:0] REG_OFF  = 2'd0;
  localparam logic [1:0] REG_SQRT = 2'd1;
  localparam logic [1:0] REG_CBRT = 2'd2;
  localparam logic [1:0] REG_SQR  = 2'd3;
  localparam int STEPS_SQRT = 4;
  localparam int STEPS_CBRT = 3;
  localparam int STEPS_SQR  = 8;
  // Highest bit index visited for a regime; the counter walks down from here to 0.
  function automatic logic [2:0] first_bit(input logic [1:0] r);
    return (r == REG_SQRT) ? 3'(STEPS_SQRT - 1) :
           (r == REG_CBRT) ? 3'(STEPS_CBRT - 1) : 3'(STEPS_SQR - 1);
  endfunction
endpackage

// File: rtl/main_unit_step.sv
// main_unit_step: one bit-serial iteration of sqrt, cbrt or square
module main_unit_step
  import main_unit_pkg::*;
(
  input  logic [1:0] regime_i,
  input  logic [7:0] acc_i,
  input  logic [2:0] k_i,
  input  logic [7:0] x_i,
  output logic [7:0] acc_o
);
  logic [7:0]  t;
  logic [15:0] t2;
  logic [23:0] t3;
  logic [7:0]  xs;
  // Trial bit for the roots, wide products so no compare can overflow, shifted addend for square
  always_comb begin
    t     = acc_i | (8'd1 << k_i);
    t2    = 16'(t) * 16'(t);
    t3    = 24'(t2) * 24'(t);
    xs    = x_i << k_i;
    acc_o = (regime_i == REG_SQRT) ? ((t2 <= 16'(x_i)) ? t : acc_i) :
            (regime_i == REG_CBRT) ? ((t3 <= 24'(x_i)) ? t : acc_i) :
            (regime_i == REG_SQR)  ? (x_i[k_i] ? acc_i + xs : acc_i) : acc_i;
  end
endmodule

// File: rtl/main_unit.sv
// main_unit: multi-mode iterative sqrt / cbrt / square unit with debug observation
module main_unit
  import main_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [1:0] on,
  input  logic       start,
  output logic [7:0] y,
  output logic [2:0] s,
  output logic       b,
  output logic       active,
  output logic [1:0] regime,
  output logic [7:0] real_state
);
  state_t     state_q;
  logic [1:0] regime_q;
  logic [7:0] acc_q, acc_d, y_q;
  logic [2:0] s_q;
  logic       b_q;
  logic [1:0] er;
  assign er = (on != REG_OFF) ? on : regime_q;
  main_unit_step u_step (
    .regime_i(regime_q),
    .acc_i   (acc_q),
    .k_i     (s_q),
    .x_i     (x),
    .acc_o   (acc_d)
  );
  // Control FSM: regime load and launch outside CALC, one result bit per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      regime_q <= REG_OFF;
      acc_q    <= 8'd0;
      y_q      <= 8'd0;
      s_q      <= 3'd0;
      b_q      <= 1'b0;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      if (s_q == 3'd0) begin
        y_q     <= acc_d;
        b_q     <= 1'b0;
        state_q <= DONE;
      end else begin
        s_q <= s_q - 3'd1;
      end
    end else begin
      if (on != REG_OFF) regime_q <= on;
      if (start && er != REG_OFF) begin
        state_q <= CALC;
        b_q     <= 1'b1;
        acc_q   <= 8'd0;
        s_q     <= first_bit(er);
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign y          = y_q;
  assign s          = s_q;
  assign b          = b_q;
  assign active     = (regime_q != REG_OFF);
  assign regime     = regime_q;
  assign real_state = acc_q;
endmodule

// File: tb/tb_main_unit.sv
// tb_main_unit: directed scoreboard bench for main_unit
module tb_main_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic [1:0] on;
  logic       start;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic       active;
  logic [1:0] regime;
  logic [7:0] real_state;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [1:0] mreg = 2'd0;

  main_unit dut (
    .clk(clk), .rst(rst), .x(x), .on(on), .start(start), .y(y), .s(s),
    .b(b), .active(active), .regime(regime), .real_state(real_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [1:0] r, input logic [7:0] v);
    int i;
    i = 0;
    if (r == 2'd1) begin
      while ((i + 1) * (i + 1) <= int'(v)) i++;
      return 8'(i);
    end
    if (r == 2'd2) begin
      while ((i + 1) * (i + 1) * (i + 1) <= int'(v)) i++;
      return 8'(i);
    end
    return 8'((int'(v) * int'(v)) % 256);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [7:0] xv, input bit hold);
    int n;
    logic [7:0] prev, e;
    @(negedge clk);
    on = op; x = xv; start = 1'b1;
    if (op != 2'd0) mreg = op;
    exp_q.push_back(model(mreg, xv));
    n = (mreg == 2'd1) ? 4 : (mreg == 2'd2) ? 3 : 8;
    prev = y;
    @(negedge clk);
    on = 2'd0;
    if (!hold) start = 1'b0;
    chk("regime_at_launch", 8'(regime), 8'(mreg));
    for (int i = 0; i < n; i++) begin
      chk("busy", 8'(b), 8'd1);
      chk("step_index", 8'(s), 8'(n - 1 - i));
      chk("y_hold", y, prev);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("busy_fall", 8'(b), 8'd0);
    chk("result", y, e);
    chk("acc", real_state, e);
  endtask

  initial begin
    rst = 1'b1; on = 2'd2; start = 1'b0; x = 8'd5;
    @(negedge clk);
    @(negedge clk);
    chk("rst_regime", 8'(regime), 8'd0);
    chk("rst_y", y, 8'd0);
    chk("rst_b", 8'(b), 8'd0);
    chk("rst_active", 8'(active), 8'd0);
    chk("rst_s", 8'(s), 8'd0);
    chk("rst_acc", real_state, 8'd0);
    rst = 1'b0; on = 2'd0;
    @(negedge clk);
    chk("hold_regime", 8'(regime), 8'd0);
    on = 2'd3;
    @(negedge clk);
    on = 2'd0;
    mreg = 2'd3;
    chk("load_regime", 8'(regime), 8'd3);
    chk("load_active", 8'(active), 8'd1);
    chk("load_no_launch", 8'(b), 8'd0);
    launch(2'd1, 8'd5, 1'b0);
    launch(2'd2, 8'd5, 1'b0);
    launch(2'd0, 8'd255, 1'b0);
    launch(2'd3, 8'd5, 1'b0);
    launch(2'd0, 8'd16, 1'b0);
    launch(2'd0, 8'd20, 1'b0);
    @(negedge clk);
    on = 2'd1;
    @(negedge clk);
    on = 2'd0;
    mreg = 2'd1;
    chk("regime_change", 8'(regime), 8'd1);
    chk("y_across_regime", y, 8'd144);
    chk("idle_busy", 8'(b), 8'd0);
    launch(2'd2, 8'd255, 1'b1);
    @(negedge clk);
    chk("relaunch_busy", 8'(b), 8'd1);
    chk("relaunch_step", 8'(s), 8'd2);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    mreg = 2'd0;
    chk("abort_y", y, 8'd0);
    chk("abort_b", 8'(b), 8'd0);
    chk("abort_s", 8'(s), 8'd0);
    chk("abort_regime", 8'(regime), 8'd0);
    chk("abort_active", 8'(active), 8'd0);
    chk("abort_acc", real_state, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(2'd1, 8'd255, 1'b0);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
